// File: rtl/cim_mem_arbiter_pkg.sv
// rtl/cim_mem_arbiter_pkg.sv - shared CiM memory arbiter constants and types
package cim_mem_arbiter_pkg;

    localparam int N_REQ        = 6;
    localparam int STARVE_LIMIT = 8;
    localparam int CIM_ADDR_W   = 16;
    localparam int N_STORAGE    = 16;

    localparam logic [N_REQ-1:0] RO_MASK = 6'b000100;

    typedef enum logic [2:0] {
        BUS_FSM                  = 3'd0,
        LOGIC_FSM                = 3'd1,
        MAC                      = 3'd2,
        LAYERNORM                = 3'd3,
        DATA_FILL_FSM            = 3'd4,
        DENSE_BROADCAST_SAVE_FSM = 3'd5
    } req_idx_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [CIM_ADDR_W-1:0] addr;
        logic [N_STORAGE-1:0]  wdata;
    } MemReq_t;

endpackage

// File: rtl/cim_prio_pick.sv
// rtl/cim_prio_pick.sv - lowest-index pick, starved requesters first
module cim_prio_pick #(
    parameter int N = 6
) (
    input  logic [N-1:0]         starved,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         win,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    logic [N-1:0] pool;

    always_comb begin
        pool  = (|starved) ? starved : req;
        win   = '0;
        idx   = '0;
        valid = |pool;
        // Descending scan so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) begin
                win    = '0;
                win[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cim_mem_arbiter.sv
// rtl/cim_mem_arbiter.sv - single-port CiM bank arbiter with starvation promotion
module cim_mem_arbiter
    import cim_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = CIM_ADDR_W,
    parameter int DATA_W = N_STORAGE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ-1:0]               we_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]               gnt_o,
    output logic [N_REQ-1:0]               rvalid_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           mem_en_o,
    output logic                           mem_wen_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    input  logic [DATA_W-1:0]              mem_rdata_i,
    output logic                           err_o
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                       state_q, state_d;
    logic                         read_pend_q, read_pend_d;
    logic [N_REQ-1:0]             gnt_d, rvalid_d;
    logic                         mem_wen_d;
    logic [ADDR_W-1:0]            mem_addr_d;
    logic [DATA_W-1:0]            mem_wdata_d;
    logic                         err_d;
    logic [N_REQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0]             ro_viol, elig, starved, win_oh;
    logic [IDX_W-1:0]             win_idx;
    logic                         win_valid;

    // Read-only writers never compete; the requester granted this cycle is
    // masked so its stale req_i cannot win twice in a row.
    always_comb begin
        ro_viol = req_i & we_i & RO_MASK;
        elig    = req_i & ~ro_viol & ~gnt_o;
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = elig[i] && (cnt_q[i] == LIMIT);
        end
    end

    cim_prio_pick #(.N(N_REQ)) u_pick (
        .starved (starved),
        .req     (elig),
        .win     (win_oh),
        .idx     (win_idx),
        .valid   (win_valid)
    );

    always_comb begin
        state_d     = win_valid ? ACCESS : IDLE;
        gnt_d       = win_oh;
        mem_wen_d   = win_valid && we_i[win_idx];
        mem_addr_d  = win_valid ? addr_i[win_idx]  : mem_addr_o;
        mem_wdata_d = win_valid ? wdata_i[win_idx] : mem_wdata_o;
        read_pend_d = win_valid && !we_i[win_idx];
        rvalid_d    = read_pend_q ? gnt_o : '0;
        err_d       = err_o | (|ro_viol);
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && !win_oh[i]) begin
                cnt_d[i] = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            read_pend_q <= 1'b0;
            gnt_o       <= '0;
            rvalid_o    <= '0;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            read_pend_q <= read_pend_d;
            gnt_o       <= gnt_d;
            rvalid_o    <= rvalid_d;
            mem_wen_o   <= mem_wen_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            err_o       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_en_o = (state_q == ACCESS);
    // The macro returns data during the rvalid cycle, so it is passed through.
    assign rdata_o  = (|rvalid_o) ? mem_rdata_i : '0;

endmodule
